gates_checker_sv: RTL and testbench

//  Self-checking stimulus/response engine for the two-input gate block.

---
 rtl/gates_checker_sv.sv | 146 ++++++++++++++
 tb/tb_gates_checker_sv.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/gates_checker_sv.sv
// Stimulus/response engine for a two-input gate block: sweeps {A,B} through 00..11,
// lets each vector settle, samples the five gate outputs and accumulates mismatches.
module gates_checker_sv #(
  parameter int SETTLE = 2,
  parameter int PASSES = 1,
  parameter int ERR_W  = 4
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iStart,
  output logic             oA,
  output logic             oB,
  input  logic             iAND,
  input  logic             iOR,
  input  logic             iNOT,
  input  logic             iNAND,
  input  logic             iNAND2,
  output logic             oBusy,
  output logic             oDone,
  output logic             oPass,
  output logic [ERR_W-1:0] oErrCnt,
  output logic [4:0]       oErrVec,
  output logic [1:0]       oVecIdx
);

  localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int PAS_W = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  state_t             state_q, state_d;
  logic [SET_W-1:0]   settle_q, settle_d;
  logic [PAS_W-1:0]   sweep_q, sweep_d;
  logic [1:0]         vec_q, vec_d;
  logic               a_q, a_d, b_q, b_d;
  logic [ERR_W-1:0]   errCnt_q, errCnt_d;
  logic [4:0]         errVec_q, errVec_d;
  logic               done_q, done_d, pass_q, pass_d;
  logic [4:0]         mis;

  // Expected values come from the registered drive bits, not from vec, so they
  // always match what the gate block is actually seeing.
  always_comb begin
    mis[0] = iAND   ^ (a_q & b_q);
    mis[1] = iOR    ^ (a_q | b_q);
    mis[2] = iNOT   ^ ~a_q;
    mis[3] = iNAND  ^ ~(a_q & b_q);
    mis[4] = iNAND2 ^ ~(a_q & b_q);
  end

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    sweep_d  = sweep_q;
    vec_d    = vec_q;
    a_d      = a_q;
    b_d      = b_q;
    errCnt_d = errCnt_q;
    errVec_d = errVec_q;
    done_d   = done_q;
    pass_d   = pass_q;
    case (state_q)
      IDLE, DONE: begin
        if (iStart) begin
          state_d  = DRIVE;
          settle_d = '0;
          sweep_d  = '0;
          vec_d    = '0;
          a_d      = 1'b0;
          b_d      = 1'b0;
          errCnt_d = '0;
          errVec_d = '0;
          done_d   = 1'b0;
          pass_d   = 1'b0;
        end
      end
      DRIVE: begin
        if (settle_q == SET_W'(SETTLE - 1)) begin
          state_d  = SAMPLE;
          settle_d = '0;
        end else begin
          settle_d = settle_q + SET_W'(1);
        end
      end
      SAMPLE: begin
        errVec_d = errVec_q | mis;
        if ((|mis) && (errCnt_q != ERR_MAX)) begin
          errCnt_d = errCnt_q + ERR_W'(1);
        end
        if ((vec_q == 2'd3) && (sweep_q == PAS_W'(PASSES - 1))) begin
          state_d = DONE;
          done_d  = 1'b1;
          pass_d  = (errCnt_d == '0);
          a_d     = 1'b0;
          b_d     = 1'b0;
        end else begin
          state_d = DRIVE;
          vec_d   = vec_q + 2'd1;
          if (vec_q == 2'd3) begin
            sweep_d = sweep_q + PAS_W'(1);
          end
          a_d = vec_d[1];
          b_d = vec_d[0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q  <= IDLE;
      settle_q <= '0;
      sweep_q  <= '0;
      vec_q    <= '0;
      a_q      <= 1'b0;
      b_q      <= 1'b0;
      errCnt_q <= '0;
      errVec_q <= '0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      sweep_q  <= sweep_d;
      vec_q    <= vec_d;
      a_q      <= a_d;
      b_q      <= b_d;
      errCnt_q <= errCnt_d;
      errVec_q <= errVec_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
    end
  end

  assign oA      = a_q;
  assign oB      = b_q;
  assign oBusy   = (state_q == DRIVE) || (state_q == SAMPLE);
  assign oDone   = done_q;
  assign oPass   = pass_q;
  assign oErrCnt = errCnt_q;
  assign oErrVec = errVec_q;
  assign oVecIdx = vec_q;

endmodule

// File: tb/tb_gates_checker_sv.sv
// Bench for gates_checker_sv: behavioural gate blocks with injectable faults, expected
// run results queued at start and checked by a monitor when oDone rises.
module tb_gates_checker_sv;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic resetN, start, start3;
  logic forceNot0, nand2Glitch;

  logic a, b, busy, done, pass;
  logic [3:0] errCnt;
  logic [4:0] errVec;
  logic [1:0] vecIdx;
  logic gAnd, gOr, gNot, gNand, gNand2;

  logic a3, b3, busy3, done3, pass3;
  logic [1:0] errCnt3;
  logic [4:0] errVec3;
  logic [1:0] vecIdx3;
  logic gOr3, gNot3, gNand3;

  int ab11Cnt = 0;

  typedef struct {
    logic       pass;
    int         cnt;
    logic [4:0] vec;
    int         lat;
  } exp_t;

  exp_t q[$];
  exp_t q3[$];
  exp_t e, e3;
  int checks = 0;
  int fails  = 0;
  int busyCnt = 0, busyCnt3 = 0;
  logic doneD = 1'b0, doneD3 = 1'b0;

  // Counts edges spent on vector 11 so the NAND2 glitch covers only the settle window.
  always @(posedge clock) ab11Cnt <= (a && b) ? ab11Cnt + 1 : 0;

  assign gAnd   = a & b;
  assign gOr    = a | b;
  assign gNot   = forceNot0 ? 1'b0 : ~a;
  assign gNand  = ~(a & b);
  assign gNand2 = ~(a & b) ^ (nand2Glitch && a && b && (ab11Cnt < 2));

  assign gOr3   = a3 | b3;
  assign gNot3  = ~a3;
  assign gNand3 = ~(a3 & b3);

  gates_checker_sv #(.SETTLE(2), .PASSES(1), .ERR_W(4)) dut (
    .iClk(clock), .iRst_n(resetN), .iStart(start), .oA(a), .oB(b),
    .iAND(gAnd), .iOR(gOr), .iNOT(gNot), .iNAND(gNand), .iNAND2(gNand2),
    .oBusy(busy), .oDone(done), .oPass(pass), .oErrCnt(errCnt),
    .oErrVec(errVec), .oVecIdx(vecIdx)
  );

  // Second instance has AND stuck at 1 to exercise saturation over two sweeps.
  gates_checker_sv #(.SETTLE(2), .PASSES(2), .ERR_W(2)) dut3 (
    .iClk(clock), .iRst_n(resetN), .iStart(start3), .oA(a3), .oB(b3),
    .iAND(1'b1), .iOR(gOr3), .iNOT(gNot3), .iNAND(gNand3), .iNAND2(gNand3),
    .oBusy(busy3), .oDone(done3), .oPass(pass3), .oErrCnt(errCnt3),
    .oErrVec(errVec3), .oVecIdx(vecIdx3)
  );

  function automatic void checkOutput(input string name, input logic [31:0] act,
                                      input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Main monitor: counts busy cycles and scores each run when oDone rises.
  always @(negedge clock) begin
    if (!resetN) begin
      busyCnt <= 0;
      doneD   <= 1'b0;
    end else begin
      if (done && !doneD) begin
        checkOutput("scoreboard entry present", q.size() > 0, 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          checkOutput("oPass", pass, e.pass);
          checkOutput("oErrCnt", errCnt, e.cnt);
          checkOutput("oErrVec", errVec, e.vec);
          checkOutput("run latency", busyCnt, e.lat);
        end
        busyCnt <= 0;
      end else if (busy) begin
        busyCnt <= busyCnt + 1;
      end
      doneD <= done;
    end
  end

  // Monitor for the saturating two-sweep instance.
  always @(negedge clock) begin
    if (!resetN) begin
      busyCnt3 <= 0;
      doneD3   <= 1'b0;
    end else begin
      if (done3 && !doneD3) begin
        checkOutput("scoreboard3 entry present", q3.size() > 0, 1);
        if (q3.size() > 0) begin
          e3 = q3.pop_front();
          checkOutput("oPass (sat)", pass3, e3.pass);
          checkOutput("oErrCnt (sat)", errCnt3, e3.cnt);
          checkOutput("oErrVec (sat)", errVec3, e3.vec);
          checkOutput("run latency (sat)", busyCnt3, e3.lat);
        end
        busyCnt3 <= 0;
      end else if (busy3) begin
        busyCnt3 <= busyCnt3 + 1;
      end
      doneD3 <= done3;
    end
  end

  task automatic pulseStart();
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
  endtask

  task automatic applyStimulus(input logic p, input int c, input logic [4:0] v, input int lat);
    q.push_back('{p, c, v, lat});
    pulseStart();
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      #1;
      if (q.size() == 0 && q3.size() == 0) break;
    end
    checkOutput("run completes in time", q.size() + q3.size(), 0);
  endtask

  initial begin
    resetN = 1'b0; start = 1'b0; start3 = 1'b0;
    forceNot0 = 1'b0; nand2Glitch = 1'b0;
    repeat (2) @(negedge clock);
    checkOutput("reset oBusy", busy, 0);
    checkOutput("reset oDone", done, 0);
    checkOutput("reset oPass", pass, 0);
    checkOutput("reset oErrCnt", errCnt, 0);
    checkOutput("reset oErrVec", errVec, 0);
    checkOutput("reset oA/oB", {a, b}, 0);
    resetN = 1'b1;

    $display("[TB] golden sweep");
    applyStimulus(1'b1, 0, 5'b00000, 12);
    for (int v = 0; v < 4; v++) begin
      checkOutput("oA/oB step", {a, b}, v);
      checkOutput("oVecIdx step", vecIdx, v);
      checkOutput("oBusy during run", busy, 1);
      repeat (3) @(negedge clock);
    end
    waitIdle();
    checkOutput("oA/oB zero in DONE", {a, b}, 0);
    checkOutput("oDone held", done, 1);

    $display("[TB] NOT stuck 0");
    forceNot0 = 1'b1;
    applyStimulus(1'b0, 2, 5'b00100, 12);
    waitIdle();
    forceNot0 = 1'b0;

    $display("[TB] AND stuck 1, saturation");
    q3.push_back('{1'b0, 3, 5'b00001, 24});
    @(negedge clock) start3 = 1'b1;
    @(negedge clock) start3 = 1'b0;
    waitIdle();

    $display("[TB] reset mid-run");
    forceNot0 = 1'b1;
    pulseStart();
    repeat (4) @(negedge clock);
    resetN = 1'b0;
    #1;
    checkOutput("abort oBusy", busy, 0);
    checkOutput("abort oDone", done, 0);
    checkOutput("abort oErrCnt", errCnt, 0);
    checkOutput("abort oErrVec", errVec, 0);
    checkOutput("abort oA/oB", {a, b}, 0);
    @(negedge clock);
    resetN = 1'b1;
    forceNot0 = 1'b0;
    applyStimulus(1'b1, 0, 5'b00000, 12);
    waitIdle();

    $display("[TB] start held high");
    q.push_back('{1'b1, 0, 5'b00000, 12});
    @(negedge clock) start = 1'b1;
    waitIdle();
    checkOutput("oDone after held start", done, 1);
    q.push_back('{1'b1, 0, 5'b00000, 12});
    @(negedge clock);
    checkOutput("oDone drops on retrigger", done, 0);
    checkOutput("oBusy on retrigger", busy, 1);
    checkOutput("oPass cleared on retrigger", pass, 0);
    start = 1'b0;
    waitIdle();

    $display("[TB] NAND2 glitch during settle only");
    nand2Glitch = 1'b1;
    applyStimulus(1'b1, 0, 5'b00000, 12);
    waitIdle();
    nand2Glitch = 1'b0;

    checkOutput("scoreboard drained", q.size() + q3.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
